// File: rtl/sink_transfer_scheduler.sv
// Round-robin sink arbiter that moves one word per grant from a sink data register
// to its routed source address using an APB read followed by an APB write.
module sink_transfer_scheduler #(
    parameter int                     NSINKS     = 4,
    parameter int                     NSOURCES   = 4,
    parameter int                     ADDR_WIDTH = 8,
    parameter int                     DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  SINK_BASE  = ADDR_WIDTH'(8'h10),
    parameter int                     TIMEOUT    = 16
) (
    input  logic                        pclk,
    input  logic                        rst,
    input  logic [NSINKS-1:0]           valids_active,
    output logic [$clog2(NSINKS)-1:0]   current_idx,
    output logic                        busy,
    output logic                        xfer_done,
    output logic                        xfer_err,
    input  logic                        route_we,
    input  logic [$clog2(NSINKS)-1:0]   route_idx,
    input  logic [ADDR_WIDTH-1:0]       route_dest,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [ADDR_WIDTH-1:0]       paddr,
    output logic [DATA_WIDTH-1:0]       pwdata,
    input  logic [DATA_WIDTH-1:0]       prdata,
    input  logic                        pready
);

    localparam int IDX_W = $clog2(NSINKS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    if (NSINKS < 2) begin : g_bad_nsinks
        $error("NSINKS must be at least 2");
    end
    if (NSOURCES < 1) begin : g_bad_nsources
        $error("NSOURCES must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_SETUP  = 3'd1,
        ST_RD_ACCESS = 3'd2,
        ST_WR_SETUP  = 3'd3,
        ST_WR_ACCESS = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t                  state_r, state_s;
    logic [IDX_W-1:0]        last_r, last_s;
    logic [IDX_W-1:0]        cur_r, cur_s;
    logic [ADDR_WIDTH-1:0]   dest_r, dest_s;
    logic [DATA_WIDTH-1:0]   data_r, data_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic                    psel_r, psel_s;
    logic                    penable_r, penable_s;
    logic                    pwrite_r, pwrite_s;
    logic [ADDR_WIDTH-1:0]   paddr_r, paddr_s;
    logic [DATA_WIDTH-1:0]   pwdata_r, pwdata_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic                    err_r, err_s;
    logic [ADDR_WIDTH-1:0]   route_r [NSINKS];
    logic                    found_s;
    logic [IDX_W-1:0]        sel_s;
    logic [IDX_W-1:0]        cand_s;
    logic                    tmo_s;

    assign current_idx = cur_r;
    assign busy        = busy_r;
    assign xfer_done   = done_r;
    assign xfer_err    = err_r;
    assign psel        = psel_r;
    assign penable     = penable_r;
    assign pwrite      = pwrite_r;
    assign paddr       = paddr_r;
    assign pwdata      = pwdata_r;

    // The abort fires on the cycle the stall count would reach TIMEOUT.
    assign tmo_s = (TIMEOUT > 0) && (cnt_r == CNT_W'(TIMEOUT - 1));

    // Round-robin search starting one past the last served sink.
    always_comb begin
        found_s = 1'b0;
        sel_s   = {IDX_W{1'b0}};
        cand_s  = {IDX_W{1'b0}};
        for (int i = 1; i <= NSINKS; i++) begin
            cand_s = IDX_W'((int'(last_r) + i) % NSINKS);
            if (!found_s && valids_active[cand_s]) begin
                found_s = 1'b1;
                sel_s   = cand_s;
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_s   = state_r;
        last_s    = last_r;
        cur_s     = cur_r;
        dest_s    = dest_r;
        data_s    = data_r;
        cnt_s     = cnt_r;
        psel_s    = psel_r;
        penable_s = penable_r;
        pwrite_s  = pwrite_r;
        paddr_s   = paddr_r;
        pwdata_s  = pwdata_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s   = ST_RD_SETUP;
                    cur_s     = sel_s;
                    dest_s    = route_r[sel_s];
                    psel_s    = 1'b1;
                    penable_s = 1'b0;
                    pwrite_s  = 1'b0;
                    paddr_s   = SINK_BASE + ADDR_WIDTH'(sel_s);
                    busy_s    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_SETUP: begin
                state_s   = ST_RD_ACCESS;
                penable_s = 1'b1;
                cnt_s     = {CNT_W{1'b0}};
            end
            ST_RD_ACCESS: begin
                if (pready) begin
                    state_s   = ST_WR_SETUP;
                    data_s    = prdata;
                    penable_s = 1'b0;
                    pwrite_s  = 1'b1;
                    paddr_s   = dest_r;
                    pwdata_s  = prdata;
                end else if (tmo_s) begin
                    state_s   = ST_DONE;
                    psel_s    = 1'b0;
                    penable_s = 1'b0;
                    pwrite_s  = 1'b0;
                    busy_s    = 1'b0;
                    done_s    = 1'b1;
                    err_s     = 1'b1;
                    last_s    = cur_r;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                state_s   = ST_WR_ACCESS;
                penable_s = 1'b1;
                cnt_s     = {CNT_W{1'b0}};
            end
            ST_WR_ACCESS: begin
                if (pready || tmo_s) begin
                    state_s   = ST_DONE;
                    psel_s    = 1'b0;
                    penable_s = 1'b0;
                    pwrite_s  = 1'b0;
                    busy_s    = 1'b0;
                    done_s    = 1'b1;
                    err_s     = !pready;
                    last_s    = cur_r;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                psel_s    = 1'b0;
                penable_s = 1'b0;
                pwrite_s  = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // State, bookkeeping and registered APB/status outputs.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            last_r    <= IDX_W'(NSINKS - 1);
            cur_r     <= {IDX_W{1'b0}};
            dest_r    <= {ADDR_WIDTH{1'b0}};
            data_r    <= {DATA_WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {ADDR_WIDTH{1'b0}};
            pwdata_r  <= {DATA_WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            last_r    <= last_s;
            cur_r     <= cur_s;
            dest_r    <= dest_s;
            data_r    <= data_s;
            cnt_r     <= cnt_s;
            psel_r    <= psel_s;
            penable_r <= penable_s;
            pwrite_r  <= pwrite_s;
            paddr_r   <= paddr_s;
            pwdata_r  <= pwdata_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
        end
    end

    // Route table; writable in any state, in-flight transfers use the latched copy.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSINKS; i++) begin
                route_r[i] <= {ADDR_WIDTH{1'b0}};
            end
        end else if (route_we && (int'(route_idx) < NSINKS)) begin
            route_r[route_idx] <= route_dest;
        end else begin
            route_r <= route_r;
        end
    end

endmodule

// File: tb/tb_sink_transfer_scheduler.sv
// Self-checking bench: table-driven single transfers plus scripted timeout,
// route-freeze, mid-transfer reset and round-robin sequences, with an APB scoreboard.
module tb_sink_transfer_scheduler;

    logic        pclk = 1'b0;
    logic        rst;
    logic [3:0]  valids_active;
    logic [1:0]  current_idx;
    logic        busy, xfer_done, xfer_err;
    logic        route_we;
    logic [1:0]  route_idx;
    logic [7:0]  route_dest;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready;

    sink_transfer_scheduler dut (
        .pclk(pclk), .rst(rst), .valids_active(valids_active),
        .current_idx(current_idx), .busy(busy), .xfer_done(xfer_done), .xfer_err(xfer_err),
        .route_we(route_we), .route_idx(route_idx), .route_dest(route_dest),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    typedef struct { logic wr; logic [7:0] addr; logic [31:0] data; } apb_t;
    typedef struct { logic [1:0] idx; logic err; } done_t;
    typedef struct { logic [3:0] mask; logic [1:0] idx; logic [7:0] dest; int rdw; int wrw; int cyc; } vec_t;

    apb_t        exp_q[$];
    done_t       done_q[$];
    vec_t        vecs[5];
    logic [31:0] sink_mem[4];
    logic [7:0]  route_m[4];
    logic [1:0]  rr_order[5];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          rd_wait, wr_wait;
    logic        ready_en;

    // Slave model: sink k's data register answers at paddr low bits; wait states counted per access.
    assign prdata = sink_mem[paddr[1:0]];
    assign pready = ready_en && (acc_cnt >= (pwrite ? wr_wait : rd_wait));
    always @(posedge pclk) cyc <= cyc + 1;
    always @(posedge pclk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_on(input bit for_done, output int t);
        int n = 0;
        while (!(for_done ? xfer_done : busy) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check(for_done ? "wait_done_bound" : "wait_grant_bound", 64'd0, 64'd1);
        t = cyc;
    endtask

    task automatic set_route(input logic [1:0] k, input logic [7:0] d);
        route_we = 1'b1; route_idx = k; route_dest = d;
        tick();
        route_we = 1'b0;
        route_m[k] = d;
    endtask

    task automatic push_xfer(input logic [1:0] k, input logic [7:0] d);
        exp_q.push_back('{1'b0, 8'h10 + {6'd0, k}, sink_mem[k]});
        exp_q.push_back('{1'b1, d, sink_mem[k]});
        done_q.push_back('{k, 1'b0});
    endtask

    // Scoreboard: every ACCESS cycle is checked against the head transaction; pops on pready.
    always @(negedge pclk) begin
        if (!rst) begin
            if (psel && penable) begin
                if (exp_q.size() == 0) begin
                    check("apb_unexpected", {56'd0, paddr}, 64'hFFFF);
                end else begin
                    check("apb_pwrite", pwrite, exp_q[0].wr);
                    check("apb_paddr", paddr, exp_q[0].addr);
                    if (pready) begin
                        check("apb_data", pwrite ? pwdata : prdata, exp_q[0].data);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (xfer_done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 64'd1, 64'd0);
                end else begin
                    check("done_idx", current_idx, done_q[0].idx);
                    check("done_err", xfer_err, done_q[0].err);
                    check("done_busy", busy, 64'd0);
                    void'(done_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tb, td, n, prev;
        rst = 1'b1; valids_active = 4'b0; route_we = 1'b0; route_idx = 2'd0; route_dest = 8'd0;
        ready_en = 1'b1; rd_wait = 0; wr_wait = 0; prev = 0;
        sink_mem[0] = 32'h1111_0000; sink_mem[1] = 32'h0BAD_F00D;
        sink_mem[2] = 32'hA5A5_0001; sink_mem[3] = 32'h5A5A_FFFF;
        for (int i = 0; i < 4; i++) route_m[i] = 8'd0;
        rr_order[0] = 2'd0; rr_order[1] = 2'd1; rr_order[2] = 2'd2; rr_order[3] = 2'd3; rr_order[4] = 2'd0;
        vecs[0] = '{4'b0100, 2'd2, 8'd1,   0, 0, 4};
        vecs[1] = '{4'b0010, 2'd1, 8'd4,   3, 2, 9};
        vecs[2] = '{4'b1001, 2'd3, 8'd7,   0, 0, 4};
        vecs[3] = '{4'b1001, 2'd0, 8'd2,   0, 0, 4};
        vecs[4] = '{4'b0011, 2'd1, 8'hFF,  1, 0, 5};

        repeat (3) tick();
        check("rst_psel", psel, 64'd0);
        check("rst_penable", penable, 64'd0);
        check("rst_pwrite", pwrite, 64'd0);
        check("rst_paddr", paddr, 64'd0);
        check("rst_pwdata", pwdata, 64'd0);
        check("rst_idx", current_idx, 64'd0);
        check("rst_busy", busy, 64'd0);
        check("rst_done", {xfer_done, xfer_err}, 64'd0);
        rst = 1'b0;
        repeat (2) tick();
        check("idle_no_grant", busy, 64'd0);

        // Busy rises the cycle after arbitration; busy-rise to xfer_done is 4 cycles plus waits.
        for (int v = 0; v < 5; v++) begin
            set_route(vecs[v].idx, vecs[v].dest);
            rd_wait = vecs[v].rdw;
            wr_wait = vecs[v].wrw;
            push_xfer(vecs[v].idx, vecs[v].dest);
            valids_active = vecs[v].mask;
            wait_on(1'b0, tb);
            valids_active = 4'b0;
            check("grant_idx", current_idx, vecs[v].idx);
            wait_on(1'b1, td);
            check("xfer_len", td - tb, vecs[v].cyc);
            repeat (2) tick();
        end

        // Timeout in RD_ACCESS: no write phase, then the next pending sink is served.
        ready_en = 1'b0; rd_wait = 0; wr_wait = 0;
        exp_q.push_back('{1'b0, 8'h12, sink_mem[2]});
        done_q.push_back('{2'd2, 1'b1});
        valids_active = 4'b1100;
        wait_on(1'b0, tb);
        valids_active = 4'b1000;
        check("tmo_grant", current_idx, 64'd2);
        wait_on(1'b1, td);
        check("tmo_len", td - tb, 64'd17);
        check("tmo_no_read_done", exp_q.size(), 64'd1);
        exp_q.delete();
        ready_en = 1'b1;
        push_xfer(2'd3, route_m[3]);
        wait_on(1'b0, tb);
        valids_active = 4'b0;
        check("tmo_next_grant", current_idx, 64'd3);
        wait_on(1'b1, td);
        repeat (2) tick();

        // Route rewrite during RD_ACCESS must not redirect the in-flight write.
        set_route(2'd1, 8'd4);
        rd_wait = 2;
        push_xfer(2'd1, 8'd4);
        valids_active = 4'b0010;
        wait_on(1'b0, tb);
        valids_active = 4'b0;
        tick();
        set_route(2'd1, 8'd3);
        wait_on(1'b1, td);
        check("freeze_len", td - tb, 64'd6);
        repeat (2) tick();

        // Reset asserted during WR_ACCESS clears outputs at once and emits no xfer_done.
        rd_wait = 0; wr_wait = 5;
        exp_q.push_back('{1'b0, 8'h10, sink_mem[0]});
        exp_q.push_back('{1'b1, route_m[0], sink_mem[0]});
        valids_active = 4'b0001;
        wait_on(1'b0, tb);
        valids_active = 4'b0;
        check("rst_seq_grant", current_idx, 64'd0);
        n = 0;
        while (!(psel && penable && pwrite) && n < 50) begin
            tick();
            n++;
        end
        check("rst_seq_wr_access", psel && penable && pwrite, 64'd1);
        rst = 1'b1;
        #1;
        check("arst_psel", psel, 64'd0);
        check("arst_penable", penable, 64'd0);
        check("arst_pwrite", pwrite, 64'd0);
        check("arst_paddr", paddr, 64'd0);
        check("arst_pwdata", pwdata, 64'd0);
        check("arst_busy_done", {busy, xfer_done, xfer_err}, 64'd0);
        exp_q.delete();
        done_q.delete();
        for (int i = 0; i < 4; i++) route_m[i] = 8'd0;
        repeat (2) tick();
        wr_wait = 0;
        valids_active = 4'b1111;
        for (int g = 0; g < 5; g++) push_xfer(rr_order[g], 8'd0);
        rst = 1'b0;

        // All sinks pending: grants 0,1,2,3,0 with a fixed 2-cycle gap from done to next busy.
        for (int g = 0; g < 5; g++) begin
            wait_on(1'b0, tb);
            check("rr_idx", current_idx, rr_order[g]);
            if (g > 0) check("rr_gap", tb - prev, 64'd2);
            wait_on(1'b1, td);
            check("rr_len", td - tb, 64'd4);
            if (g == 4) valids_active = 4'b0;
            prev = td;
        end
        repeat (5) tick();
        check("final_busy", busy, 64'd0);
        check("final_queues", exp_q.size() + done_q.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
